// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 32-bit MIPS core.
// Owns the PC register and picks the next fetch address from sequential,
// branch, jump and jump-register sources, with stall handling and a
// one-cycle flush pulse after every applied redirect.
// Optional feature macro: PC_SEQ_EXCEPTION_EN adds the exc input, the epc
// output and the exception redirect (highest priority, loads EXC_VECTOR).
//
// Handshake note: there is no valid/ready pair here. stall=1 means "hold pc
// this cycle"; a redirect seen while stalled is remembered and applied on the
// first edge with stall=0. Redirect inputs only count while fetch_valid=1.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
`ifdef PC_SEQ_EXCEPTION_EN
  input  logic        exc,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush
`ifdef PC_SEQ_EXCEPTION_EN
  ,
  output logic [31:0] epc
`endif
);

  localparam logic [1:0] ST_BOOT      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_HOLD_PEND = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        flush_q, flush_d;
`ifdef PC_SEQ_EXCEPTION_EN
  logic [31:0] epc_q, epc_d;
  logic        pending_exc_q, pending_exc_d;
`endif

  logic        exc_req;
  logic        redir_req;
  logic [31:0] branch_tgt;
  logic [31:0] redir_tgt;
  logic        unused_bits;

  assign fetch_valid = (state_q != ST_BOOT);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign flush       = flush_q;
`ifdef PC_SEQ_EXCEPTION_EN
  assign epc         = epc_q;
  assign exc_req     = exc & fetch_valid;
`else
  assign exc_req     = 1'b0;
`endif

  // Word-aligned register targets drop the two low bits of jr_target.
  assign unused_bits = ^jr_target[1:0];

  // Resolve the highest-priority redirect request and its target address.
  always_comb begin
    branch_tgt = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    redir_req  = fetch_valid & (exc_req | jr | jump | branch_taken);
    redir_tgt  = branch_tgt;
    if (exc_req) begin
      redir_tgt = EXC_VECTOR;
    end else if (jr) begin
      redir_tgt = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      redir_tgt = {pc_plus4[31:28], jump_target, 2'b00};
    end
  end

  // Next-state logic: advance, redirect, hold, or remember a stalled redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    flush_d       = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
    epc_d         = epc_q;
    pending_exc_d = pending_exc_q;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (!stall) begin
          state_d = ST_RUN;
          if (redir_req) begin
            pc_d    = redir_tgt;
            flush_d = 1'b1;
`ifdef PC_SEQ_EXCEPTION_EN
            if (exc_req) epc_d = pc_q;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end else if (redir_req) begin
          pending_d     = redir_tgt;
`ifdef PC_SEQ_EXCEPTION_EN
          pending_exc_d = exc_req;
`endif
          state_d       = ST_HOLD_PEND;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD_PEND: begin
        if (!stall) begin
          // pc has not moved while stalled, so it is still the faulting pc.
          pc_d    = pending_q;
          flush_d = 1'b1;
          state_d = ST_RUN;
`ifdef PC_SEQ_EXCEPTION_EN
          if (pending_exc_q) epc_d = pc_q;
`endif
        end else if (exc_req) begin
          pending_d     = EXC_VECTOR;
`ifdef PC_SEQ_EXCEPTION_EN
          pending_exc_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      pending_q     <= 32'd0;
      flush_q       <= 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
      epc_q         <= 32'd0;
      pending_exc_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      flush_q       <= flush_d;
`ifdef PC_SEQ_EXCEPTION_EN
      epc_q         <= epc_d;
      pending_exc_q <= pending_exc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized bench for pc_sequencer.
// The reference model tracks only "booted", the pc, and an optional pending
// redirect; RUN and HOLD behave alike from the outside. Exception checks are
// built only when PC_SEQ_EXCEPTION_EN is defined.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0080;
`ifdef PC_SEQ_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  // Clock and DUT signals
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_SEQ_EXCEPTION_EN
  logic [31:0] epc;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
`ifdef PC_SEQ_EXCEPTION_EN
    .exc           (exc),
`endif
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .flush         (flush)
`ifdef PC_SEQ_EXCEPTION_EN
    ,
    .epc           (epc)
`endif
  );

  // Reference model state and scoreboard
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_pend;
  logic [31:0] m_pt;
  bit          m_pexc;
  bit          m_flush;
  logic [31:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, exp_q.pop_front());
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_run});
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
`ifdef PC_SEQ_EXCEPTION_EN
    chk("epc", epc, m_epc);
`endif
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; branch_offset = 16'd0; jump = 0;
    jump_target = 26'd0; jr = 0; jr_target = 32'd0; exc = 0;
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // let the DUT take the same edge and compare.
  task automatic step();
    logic [31:0] p4, t, soff;
    bit req, isx;
    p4   = m_pc + 32'd4;
    soff = {{16{branch_offset[15]}}, branch_offset};
    req  = 1'b1;
    isx  = 1'b0;
    if (EXC_EN && exc) begin t = EV; isx = 1'b1; end
    else if (jr)           t = jr_target & 32'hFFFF_FFFC;
    else if (jump)         t = (p4 & 32'hF000_0000) | ({6'd0, jump_target} * 32'd4);
    else if (branch_taken) t = p4 + soff * 32'd4;
    else begin t = p4; req = 1'b0; end

    m_flush = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
    end else if (!stall) begin
      if (m_pend) begin
        if (m_pexc) m_epc = m_pc;
        m_pc = m_pt; m_pend = 1'b0; m_flush = 1'b1;
      end else if (req) begin
        if (isx) m_epc = m_pc;
        m_pc = t; m_flush = 1'b1;
      end else begin
        m_pc = p4;
      end
    end else if (!m_pend) begin
      if (req) begin m_pend = 1'b1; m_pt = t; m_pexc = isx; end
    end else if (EXC_EN && exc) begin
      m_pt = EV; m_pexc = 1'b1;
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse, checked while rst_n is still low.
  task automatic do_reset();
    idle();
    rst_n   = 1'b0;
    m_run   = 1'b0;
    m_pc    = RV;
    m_epc   = 32'd0;
    m_pend  = 1'b0;
    m_pt    = 32'd0;
    m_pexc  = 1'b0;
    m_flush = 1'b0;
    #2;
    exp_q.push_back(m_pc);
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and boot: one non-valid cycle at pc=0, then 0,4,8,C,10
    do_reset();
    step();
    step();
    step();
    step();
    step();
    chk("boot_pc_0x10", pc, 32'h10);

    // Backward branch from 0x10 with offset -2 lands on 0x0C
    branch_taken = 1; branch_offset = 16'hFFFE;
    step();
    chk("branch_target", pc, 32'h0C);
    idle();
    step();

    // Jump beats branch in the same cycle
    jr = 1; jr_target = 32'h1000_0040;
    step();
    idle();
    jump = 1; jump_target = 26'h000_0100; branch_taken = 1; branch_offset = 16'h0005;
    step();
    chk("jump_over_branch", pc, 32'h1000_0400);

    // JR captured during a three-cycle stall, applied after stall drops
    idle(); jr = 1; jr_target = 32'h20;
    step();
    idle(); stall = 1; jr = 1; jr_target = 32'h0000_0303;
    step();
    idle(); stall = 1;
    step();
    step();
    chk("stall_hold_pc", pc, 32'h20);
    idle();
    step();
    chk("stall_redirect_pc", pc, 32'h300);
    step();

    // Wrap past the top of the address space
    jr = 1; jr_target = 32'hFFFF_FFFF;
    step();
    idle();
    step();
    chk("wrap_to_zero", pc, 32'h0);

    // Pending jump discarded by a reset in the middle of the stall
    stall = 1; jump = 1; jump_target = 26'h3AB_CDEF;
    step();
    idle(); stall = 1;
    step();
    do_reset();
    step();
    step();
    step();
    chk("no_stale_jump", pc, 32'h8);

`ifdef PC_SEQ_EXCEPTION_EN
    // Exception outranks jr and records the faulting pc
    jr = 1; jr_target = 32'h44;
    step();
    idle(); exc = 1; jr = 1; jr_target = 32'h0000_1230;
    step();
    chk("exc_pc", pc, EV);
    chk("exc_epc", epc, 32'h44);
    // Exception replaces a pending jr while stalled
    idle(); jr = 1; jr_target = 32'h600;
    step();
    idle(); stall = 1; jr = 1; jr_target = 32'h900;
    step();
    idle(); stall = 1; exc = 1;
    step();
    idle();
    step();
    chk("exc_pend_epc", epc, 32'h600);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        stall         = ($urandom_range(0, 9) < 3);
        branch_taken  = ($urandom_range(0, 9) < 2);
        branch_offset = 16'($urandom);
        jump          = ($urandom_range(0, 9) == 0);
        jump_target   = 26'($urandom);
        jr            = ($urandom_range(0, 9) == 0);
        jr_target     = $urandom;
        exc           = EXC_EN && ($urandom_range(0, 19) == 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 32-bit MIPS core. It owns the PC register and selects the next PC each cycle from sequential, branch, jump and jump-register sources. It applies stalls, including a redirect that arrives while stalled, and emits a one-cycle flush pulse on every taken redirect. It sits between the control unit and instruction memory, replacing a free-running PC register.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, exception handler address (used only with PC_SEQ_EXCEPTION_EN)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hold PC this cycle
- branch_taken  input  1  conditional branch resolved taken for the instruction at pc
- branch_offset  input  16  signed word offset
- jump  input  1  J/JAL for the instruction at pc
- jump_target  input  26  instruction index field
- jr  input  1  JR/JALR for the instruction at pc
- jr_target  input  32  register-sourced target
- exc  input  1  exception request (macro-gated)
- pc  output  32  current fetch address
- pc_plus4  output  32  pc + 4
- fetch_valid  output  1  pc is a valid fetch address this cycle
- flush  output  1  one-cycle pulse after a redirect is applied
- epc  output  32  address of the excepting instruction (macro-gated)

## Operation
- Redirect priority: exc > jr > jump > branch_taken > sequential. Lower-priority requests in the same cycle are dropped.
- Targets are computed from the current pc:
  - branch: pc_plus4 + (sign_extend(branch_offset) << 2)
  - jump: {pc_plus4[31:28], jump_target, 2'b00}
  - jr: {jr_target[31:2], 2'b00}. Low bits are forced to zero.
- All adds are 32-bit modulo. pc 32'hFFFF_FFFC with sequential next gives 32'h0000_0000.
- The redirect inputs and exc are ignored while fetch_valid=0.
- FSM states:
  - BOOT: after reset. fetch_valid=0, pc holds. Goes to RUN on the next edge unconditionally. stall is ignored.
  - RUN: fetch_valid=1. If stall=0, pc <= next. If stall=1 with a redirect, the target is captured in pending_target and the state goes to HOLD_PEND. If stall=1 with no redirect, the state goes to HOLD.
  - HOLD: fetch_valid=1, pc holds. A redirect while stall=1 is captured and the state goes to HOLD_PEND. When stall=0, the state acts as RUN for that cycle and returns to RUN.
  - HOLD_PEND: fetch_valid=1, pc holds. Further redirects are ignored, except that exc replaces pending_target. When stall=0, pc <= pending_target, flush=1 next cycle, and the state goes to RUN.
- flush is asserted in the cycle after any redirect is loaded into pc. It is never asserted for sequential advance.

## Timing
- Reset (async, on rst_n low):
  - pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4
  - fetch_valid=0, flush=0, epc=0
  - pending_target=0, state BOOT
- Reset asserted mid-HOLD_PEND discards the pending redirect.
- First fetch: fetch_valid=1 one edge after rst_n rises. The first pc advance happens on the following edge.
- Redirect latency in RUN: 1 cycle. pc equals the target and flush=1 in the cycle after the request.
- Redirect during stall: pc equals the target and flush=1 in the cycle after the first stall=0 edge.
- pc_plus4 is combinational from pc.

## Configuration
- PC_SEQ_EXCEPTION_EN defined:
  - exc and epc ports exist.
  - An exc redirect loads EXC_VECTOR and sets epc <= pc (the faulting pc) on the same edge.
- PC_SEQ_EXCEPTION_EN undefined:
  - exc and epc ports are absent.
  - Priority is jr > jump > branch > sequential; no EPC register is built.

## Test plan
- Reset and boot: rst_n low then high, no stall → fetch_valid=0 for one cycle at pc=0, then pc=0,4,8,C on successive edges; flush never set.
- Branch: at pc=0x10, branch_taken=1, offset=16'hFFFE (-2) → next pc=0x0C, flush=1 for one cycle.
- Jump vs branch: at pc=0x1000_0040, jump=1, jump_target=26'h0000100 and branch_taken=1 in the same cycle → pc=0x1000_0400 (jump wins).
- Redirect under stall: stall=1 for 3 cycles at pc=0x20, jr=1, jr_target=0x0000_0303 in cycle 1 → pc holds 0x20 through the stall, then pc=0x300 with flush=1 after stall drops.
- Wrap and mid-stall reset: pc=0xFFFF_FFFC, sequential → 0x0; then stall with a pending jump, pulse rst_n low → pc=RESET_VECTOR, state BOOT, pending jump never applied.
- Exception (macro on): at pc=0x44, exc=1 together with jr=1 → pc=0x80, epc=0x44, flush=1.
